macc_unit: RTL and testbench
============================

Name: macc_unit

Overview:
- Signed multiply-accumulate block: P <= P ± A*B + CARRYIN every enabled clock.
- Optional preload of the accumulator from a data input.
- Configurable pipeline latency of 1-4 cycles.
- Used by the convolution filter: one image pixel times one filter weight per cycle, accumulated into an activation.

Parameters:
- DEVICE, "7SERIES", target family string ("VIRTEX5","VIRTEX6","SPARTAN6","7SERIES"); informational only, no functional effect; any other value is an elaboration error.
- LATENCY, 1, clock cycles from input sample to P update; legal 1-4.
- WIDTH_A, 18, A operand width; legal 1-25.
- WIDTH_B, 18, B operand width; legal 1-18.
- WIDTH_P, 48, accumulator/output width; legal 1-48.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable, active-high; gates all registers.
- a  in  WIDTH_A  multiplicand, signed two's complement.
- b  in  WIDTH_B  multiplier, signed two's complement.
- addsub  in  1  1 = add product, 0 = subtract.
- carryin  in  1  carry into the accumulator adder.
- load  in  1  1 = replace accumulator feedback with load_data.
- load_data  in  WIDTH_P  preload value.
- p  out  WIDTH_P  accumulator register, driven directly from a register.

Behaviour:
- Reset: rst high asynchronously clears the accumulator and every pipeline stage to 0, so p = 0. It holds while rst is high, overrides ce, and is released synchronously on the next edge.
- Product: prod = signed(a) * signed(b), sign-extended or truncated to WIDTH_P.
- Base: base = load ? load_data : p.
- Update when addsub=1: acc_next = base + prod + carryin.
- Update when addsub=0: acc_next = base - (prod + carryin).
- All arithmetic wraps modulo 2^WIDTH_P; there is no saturation or overflow flag.
- Pipeline: a, b, addsub, carryin, load and load_data all pass through LATENCY-1 identical register stages, then the accumulator register.
  - LATENCY=1: inputs present at edge n are reflected in p after edge n.
  - LATENCY=L: inputs are reflected in p after edge n+L-1.
  - Control and data stay aligned, so load/addsub apply to their own sample.
- Accumulator feedback always uses the current p, not a pipelined copy: back-to-back samples accumulate correctly at any latency.
- ce=0: every stage and the accumulator hold; p is unchanged; inputs presented during that cycle are dropped.
- ce toggling mid-stream: samples advance only on ce=1 edges; the pipeline never loses or duplicates a captured sample.
- load=1 with addsub=0: p = load_data - prod - carryin.
- Reset mid-operation: all in-flight samples are discarded; accumulation restarts from 0 with the first sample after release.
- Illegal parameter values cause an elaboration-time error (generate-time assertion).

Decomposition:
- Shared package macc_pkg holds:
  - legal-range constants: LAT_MIN=1, LAT_MAX=4, WA_MAX=25, WB_MAX=18, WP_MAX=48;
  - the device-name enumeration/strings.
- One natural sub-module: macc_delay_line, a parameterised width × depth register chain with ce and async rst.
  - Instantiated once on the concatenated input bundle, depth LATENCY-1.
  - Depth 0 is a pass-through.
- Multiplier, adder and accumulator stay in macc_unit.

Test Plan:
- LATENCY=1, defaults: reset, then a=3,b=26,addsub=1 for one cycle, then a=2,b=25 -> p=78 after first edge, p=128 after second; rst pulse mid-stream -> p=0 immediately, asynchronously.
- Signed/subtract:
  - from p=0, a=-4,b=5,addsub=1 -> p=-20;
  - next a=3,b=2,addsub=0,carryin=1 -> p=-27.
- Load: p=100, load=1, load_data=1000, a=2,b=3,addsub=1 -> p=1006; next load=0, a=1,b=1 -> p=1007.
- Clock enable: p=50, ce=0 for 3 cycles with a=7,b=7 -> p stays 50; ce=1 with a=1,b=1 -> p=51.
- LATENCY=3:
  - a=2,b=3 at edge 0 -> p still 0 after edges 0 and 1, p=6 after edge 2;
  - continuous stream a=1,b=1 for 5 cycles -> p increments by 1 per cycle once the pipeline fills.
- Wrap: WIDTH_P=8, load_data=250 with load=1, a=3,b=2 -> p=0 (256 mod 256); then a=-1,b=1 -> p=255.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared constants for the multiply-accumulate block: legal parameter ranges
// and the recognised target family names.
package macc_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int WA_MAX  = 25;
  localparam int WB_MAX  = 18;
  localparam int WP_MAX  = 48;

  typedef enum logic [1:0] {
    DEV_VIRTEX5,
    DEV_VIRTEX6,
    DEV_SPARTAN6,
    DEV_7SERIES
  } device_e;

  localparam string DEV_NAME_VIRTEX5  = "VIRTEX5";
  localparam string DEV_NAME_VIRTEX6  = "VIRTEX6";
  localparam string DEV_NAME_SPARTAN6 = "SPARTAN6";
  localparam string DEV_NAME_7SERIES  = "7SERIES";

endpackage

// File: rtl/macc_delay_line.sv
// WIDTH x DEPTH register chain with clock enable and async active-high reset.
// Depth 0 degenerates to a wire.
module macc_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk_i, rst_i, ce_i};
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/macc_unit.sv
// Signed multiply-accumulate: p <= (load ? load_data : p) +/- (a*b + carryin),
// with LATENCY-1 aligned input stages ahead of the accumulator register.
module macc_unit #(
  parameter string DEVICE  = "7SERIES",
  parameter int    LATENCY = 1,
  parameter int    WIDTH_A = 18,
  parameter int    WIDTH_B = 18,
  parameter int    WIDTH_P = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               addsub,
  input  logic               carryin,
  input  logic               load,
  input  logic [WIDTH_P-1:0] load_data,
  output logic [WIDTH_P-1:0] p
);
  import macc_pkg::*;

  localparam bit DEVICE_OK = (DEVICE == DEV_NAME_VIRTEX5)  || (DEVICE == DEV_NAME_VIRTEX6) ||
                             (DEVICE == DEV_NAME_SPARTAN6) || (DEVICE == DEV_NAME_7SERIES);

  if (!DEVICE_OK) begin : g_bad_device
    $error("macc_unit: unsupported DEVICE %s", DEVICE);
  end
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("macc_unit: LATENCY %0d out of range", LATENCY);
  end
  if (WIDTH_A < 1 || WIDTH_A > WA_MAX) begin : g_bad_wa
    $error("macc_unit: WIDTH_A %0d out of range", WIDTH_A);
  end
  if (WIDTH_B < 1 || WIDTH_B > WB_MAX) begin : g_bad_wb
    $error("macc_unit: WIDTH_B %0d out of range", WIDTH_B);
  end
  if (WIDTH_P < 1 || WIDTH_P > WP_MAX) begin : g_bad_wp
    $error("macc_unit: WIDTH_P %0d out of range", WIDTH_P);
  end

  localparam int BW  = WIDTH_A + WIDTH_B + 3 + WIDTH_P;
  localparam int WPR = WIDTH_A + WIDTH_B;

  logic [BW-1:0] bundle_in;
  logic [BW-1:0] bundle_dly;

  // Data and control share one chain so each sample keeps its own load/addsub.
  assign bundle_in = {a, b, addsub, carryin, load, load_data};

  macc_delay_line #(
    .WIDTH(BW),
    .DEPTH(LATENCY - 1)
  ) u_delay (
    .clk_i(clk),
    .rst_i(rst),
    .ce_i (ce),
    .d_i  (bundle_in),
    .q_o  (bundle_dly)
  );

  logic signed [WIDTH_A-1:0] a_s;
  logic signed [WIDTH_B-1:0] b_s;
  logic                      addsub_s;
  logic                      carryin_s;
  logic                      load_s;
  logic        [WIDTH_P-1:0] load_data_s;

  assign {a_s, b_s, addsub_s, carryin_s, load_s, load_data_s} = bundle_dly;

  logic signed [WPR-1:0]     prod_full;
  logic        [WIDTH_P-1:0] prod_p;

  assign prod_full = a_s * b_s;
  assign prod_p    = WIDTH_P'(prod_full);

  logic [WIDTH_P-1:0] p_q;
  logic [WIDTH_P-1:0] p_d;
  logic [WIDTH_P-1:0] base;
  logic [WIDTH_P-1:0] cin_p;

  // Feedback always taps the live accumulator, never a delayed copy.
  always_comb begin
    base  = load_s ? load_data_s : p_q;
    cin_p = WIDTH_P'(carryin_s);
    p_d   = p_q;
    if (addsub_s) p_d = base + prod_p + cin_p;
    else          p_d = base - (prod_p + cin_p);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     p_q <= '0;
    else if (ce) p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: tb/tb_macc_unit.sv
// Scoreboard bench for macc_unit: three instances (latency 1, latency 3,
// 8-bit accumulator) share one randomized stimulus stream.
module tb_macc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic        addsub = 1'b0;
  logic        carryin = 1'b0;
  logic        load = 1'b0;
  logic [47:0] load_data = '0;
  logic [47:0] p1;
  logic [47:0] p3;
  logic [7:0]  p8;

  always #5 clk = ~clk;

  macc_unit u_lat1 (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .addsub(addsub),
    .carryin(carryin), .load(load), .load_data(load_data), .p(p1)
  );

  macc_unit #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .addsub(addsub),
    .carryin(carryin), .load(load), .load_data(load_data), .p(p3)
  );

  macc_unit #(.WIDTH_P(8)) u_w8 (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .addsub(addsub),
    .carryin(carryin), .load(load), .load_data(load_data[7:0]), .p(p8)
  );

  typedef struct packed {
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic               add;
    logic               cin;
    logic               load;
    logic [47:0]        ld;
  } samp_t;

  typedef struct packed {
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  int     total = 0;
  int     bad = 0;
  exp_t   expq[$];
  samp_t  pending[3][$];
  longint pm[3];
  int     lats[3] = '{1, 3, 1};
  int     wps[3]  = '{48, 48, 8};

  // Reference: each accepted sample takes effect lats-1 enabled edges later.
  function automatic longint apply(longint pv, samp_t s, int w);
    longint mask = (longint'(1) << w) - 1;
    longint sa = s.a;
    longint sb = s.b;
    longint prod = sa * sb;
    longint base = s.load ? (longint'(s.ld) & mask) : pv;
    longint nxt = s.add ? (base + prod + longint'(s.cin)) : (base - (prod + longint'(s.cin)));
    return nxt & mask;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      pm[k] = 0;
      pending[k].delete();
      for (int j = 0; j < lats[k] - 1; j++) pending[k].push_back('0);
    end
  endfunction

  function automatic void model_edge(samp_t s);
    samp_t cur;
    for (int k = 0; k < 3; k++) begin
      pending[k].push_back(s);
      cur = pending[k].pop_front();
      pm[k] = apply(pm[k], cur, wps[k]);
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.e0 = pm[0];
    e.e1 = pm[1];
    e.e2 = pm[2];
    expq.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares after every falling edge and just after reset rises.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        chk("p_lat1", {16'b0, p1}, e.e0);
        chk("p_lat3", {16'b0, p3}, e.e1);
        chk("p_w8",   {56'b0, p8}, e.e2);
      end
    end
  end

  task automatic cycle(input int ta, input int tbv, input bit tadd, input bit tcin,
                       input bit tload, input longint tld, input bit tce);
    samp_t s;
    a = 18'(ta);
    b = 18'(tbv);
    addsub = tadd;
    carryin = tcin;
    load = tload;
    load_data = 48'(tld);
    ce = tce;
    s.a = a;
    s.b = b;
    s.add = addsub;
    s.cin = carryin;
    s.load = load;
    s.ld = load_data;
    @(posedge clk);
    #1;
    if (tce) model_edge(s);
    push_exp();
  endtask

  // Reset rises mid-cycle so the monitor sees p clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    push_exp();
    a = '0; b = '0; addsub = 1'b0; carryin = 1'b0; load = 1'b0; load_data = '0; ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    cycle(3, 26, 1, 0, 0, 0, 1);
    cycle(2, 25, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    do_reset();

    cycle(-4, 5, 1, 0, 0, 0, 1);
    cycle(3, 2, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);

    do_reset();
    cycle(0, 0, 1, 0, 1, 100, 1);
    cycle(2, 3, 1, 0, 1, 1000, 1);
    cycle(1, 1, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);

    do_reset();
    cycle(0, 0, 1, 0, 1, 50, 1);
    for (int i = 0; i < 3; i++) cycle(7, 7, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);

    do_reset();
    cycle(2, 3, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 1);

    do_reset();
    cycle(3, 2, 1, 0, 1, 250, 1);
    cycle(-1, 1, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(3, -2, 0, 1, 1, 5, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        cycle(int'($urandom), int'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), longint'({$urandom, $urandom}),
              ($urandom_range(0, 3) != 0));
      end
    end

    @(negedge clk);
    #2;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
